// File: rtl/alu_exec_unit_pkg.sv
// Shared ALUControl encodings, FSM state encodings and operand width for the ALU execute unit.
// The command encoding matches the controller's ALU decode stage bit for bit.
package alu_exec_unit_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_DONE  = 2'b10;

    function automatic logic is_shift(input logic [2:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_exec_unit_comb_core.sv
// Purely combinational ALU core: add/sub/and/or/xor/slt in one pass.
// Shift codes pass operand A through; only the zero-shamt case ever uses that path.
module alu_comb_core
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    logic [XLEN-1:0] diff;
    logic            overflow;
    logic            less;

    // Subtraction shares one adder form: a + ~b + 1.
    assign diff     = a + ~b + {{(XLEN-1){1'b0}}, 1'b1};
    assign overflow = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
    assign less     = diff[XLEN-1] ^ overflow;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves y unassigned (no latch).
        y = a;
        case (ctrl)
            ALU_ADD: y = a + b;
            ALU_SUB: y = diff;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLT: y = {{(XLEN-1){1'b0}}, less};
            default: y = a;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit with valid/ready on both sides: single-cycle ops via alu_comb_core,
// shifts via an iterative one-bit-per-cycle shifter driven by a 5-bit down counter.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      alu_ctrl_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);

    logic [1:0]      state;
    logic [4:0]      count;
    logic [XLEN-1:0] acc;
    logic            shift_left;
    logic [XLEN-1:0] core_y;
    logic [XLEN-1:0] acc_next;
    logic [4:0]      shamt;

    assign shamt       = b_i[4:0];
    assign in_ready_o  = (state == S_IDLE);
    assign out_valid_o = (state == S_DONE);

    alu_comb_core #(.XLEN(XLEN)) u_core (
        .ctrl (alu_ctrl_i),
        .a    (a_i),
        .b    (b_i),
        .y    (core_y)
    );

    assign acc_next = shift_left ? (acc << 1) : (acc >> 1);

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= '0;
            acc        <= '0;
            shift_left <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b1;
        end else if (flush_i) begin
            // Abort wins over everything; the last result stays visible but unflagged.
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        if (is_shift(alu_ctrl_i) && (shamt != 5'd0)) begin
                            acc        <= a_i;
                            count      <= shamt;
                            shift_left <= (alu_ctrl_i == ALU_SLL);
                            state      <= S_SHIFT;
                        end else begin
                            result_o <= core_y;
                            zero_o   <= (core_y == '0);
                            state    <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    acc   <= acc_next;
                    count <= count - 5'd1;
                    if (count == 5'd1) begin
                        result_o <= acc_next;
                        zero_o   <= (acc_next == '0);
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Returning through IDLE gives the intentional one-cycle bubble.
                    if (out_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  alu_ctrl;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_res = 32'h0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .alu_ctrl_i  (alu_ctrl),
        .a_i         (a_in),
        .b_i         (b_in),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .zero_o      (zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL: return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    // Accept edge, then one edge per remaining shift step: shamt+1 edges for a real shift.
    function automatic int model_latency(input logic [2:0] c, input logic [31:0] b);
        if ((c == ALU_SLL || c == ALU_SRL) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp;
        int          lat;
        exp = model(c, a, b);
        @(negedge clk);
        check("idle_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        alu_ctrl = c;
        a_in     = a;
        b_in     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, model_latency(c, b));
        check("result", result, exp);
        check("zero", {31'b0, zero}, {31'b0, exp == 32'h0});
        check("done_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_result", result, exp);
            check("hold_ready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drain_valid", {31'b0, out_valid}, 32'd0);
        check("drain_ready", {31'b0, in_ready}, 32'd1);
        last_res = exp;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_ctrl  = ALU_ADD;
        a_in      = 32'h0;
        b_in      = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Arithmetic corners, including the signed-overflow slt case.
        run_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 0);
        run_op(ALU_SUB, 32'd5, 32'd5, 0);
        run_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(ALU_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 0);
        run_op(ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 0);

        // Shift corners: maximum shamt, upper b bits ignored, zero shamt passthrough.
        run_op(ALU_SLL, 32'h1, 32'd31, 0);
        run_op(ALU_SRL, 32'h8000_0000, 32'h24, 0);
        run_op(ALU_SLL, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 0);
        run_op(ALU_SRL, 32'h1, 32'd1, 0);

        // Downstream stall in DONE.
        run_op(ALU_XOR, 32'h1234_5678, 32'h0F0F_0F0F, 10);

        // Flush in SHIFT once the counter is down to 7.
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctrl = ALU_SLL;
        a_in     = 32'h3;
        b_in     = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            check("pre_flush_valid", {31'b0, out_valid}, 32'd0);
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_ready", {31'b0, in_ready}, 32'd1);
        check("flush_result", result, last_res);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            check("post_flush_valid", {31'b0, out_valid}, 32'd0);
        end

        // Flush together with in_valid in IDLE drops the command.
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        alu_ctrl = ALU_ADD;
        a_in     = 32'd1;
        b_in     = 32'd1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("drop_valid", {31'b0, out_valid}, 32'd0);
            check("drop_ready", {31'b0, in_ready}, 32'd1);
        end
        check("drop_result", result, last_res);

        // Randomized ops against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            c = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (n % 5 == 0) b = a;
            run_op(c, a, b, int'($urandom_range(0, 2)));
        end

        // Make sure a nonzero result is visible before the asynchronous reset test.
        run_op(ALU_OR, 32'hA5A5_0000, 32'h0000_5A5A, 0);
        @(negedge clk);
        in_valid = 1'b1;
        alu_ctrl = ALU_SLL;
        a_in     = 32'h1;
        b_in     = 32'd10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", {31'b0, in_ready}, 32'd1);
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_result", result, 32'h0);
        check("arst_zero", {31'b0, zero}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        last_res = 32'h0;

        // Back-to-back ops after reset.
        run_op(ALU_AND, 32'hFFFF_0000, 32'h0F0F_F0F0, 0);
        run_op(ALU_SRL, 32'hF000_0000, 32'd3, 0);
        run_op(ALU_SUB, 32'd0, 32'd1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
